// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch-target add, destination select and the EX/MEM register.
// Also holds an iterative 32-step mul/div unit with HI/LO that stalls upstream while busy.
module ex_stage #(
  parameter int MD_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_ex,
  input  logic        ctrl_regWrite_id_ex,
  input  logic        ctrl_memToReg_id_ex,
  input  logic        ctrl_branch_id_ex,
  input  logic        ctrl_memRead_id_ex,
  input  logic        ctrl_memWrite_id_ex,
  input  logic        ctrl_regDest_id_ex,
  input  logic        ctrl_aluSrc_id_ex,
  input  logic [1:0]  ctrl_aluOp_id_ex,
  input  logic [31:0] supposed_next_address_id_ex,
  input  logic [31:0] read_data_1_id_ex,
  input  logic [31:0] read_data_2_id_ex,
  input  logic [31:0] extended_branch_offset_id_ex,
  input  logic [4:0]  next_instruction_20_16_id_ex,
  input  logic [4:0]  next_instruction_15_11_id_ex,
  output logic        stall_ex,
  output logic        ctrl_regWrite_ex_mem,
  output logic        ctrl_memToReg_ex_mem,
  output logic        ctrl_branch_ex_mem,
  output logic        ctrl_memRead_ex_mem,
  output logic        ctrl_memWrite_ex_mem,
  output logic [31:0] branch_address_ex_mem,
  output logic        alu_zero_ex_mem,
  output logic [31:0] alu_result_ex_mem,
  output logic [31:0] write_data_ex_mem,
  output logic [4:0]  write_register_ex_mem
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B, F_SLL = 6'h00, F_SRL  = 6'h02;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, op_b_q, op_b_d;
  logic        is_div_q, is_div_d, is_signed_q, is_signed_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, branch_q, branch_d;
  logic        memread_q, memread_d, memwrite_q, memwrite_d, zero_q, zero_d;
  logic [31:0] baddr_q, baddr_d, result_q, result_d, wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;

  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        is_r, is_md, md_issue, bubble;
  logic [32:0] mul_sum, div_sh;
  logic [63:0] prod;

  assign funct    = extended_branch_offset_id_ex[5:0];
  assign shamt    = extended_branch_offset_id_ex[10:6];
  assign alu_a    = read_data_1_id_ex;
  assign alu_b    = ctrl_aluSrc_id_ex ? extended_branch_offset_id_ex : read_data_2_id_ex;
  assign is_r     = (ctrl_aluOp_id_ex == 2'b10);
  assign is_md    = is_r && (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU);
  assign md_issue = (state_q == S_IDLE) && is_md && !flush_ex;
  assign stall_ex = md_issue || (state_q == S_BUSY);
  assign bubble   = flush_ex || stall_ex;

  always_comb begin
    alu_res = 32'd0;
    unique case (ctrl_aluOp_id_ex)
      2'b01: alu_res = alu_a - alu_b;
      2'b10: begin
        case (funct)
          F_ADD, F_ADDU: alu_res = alu_a + alu_b;
          F_SUB, F_SUBU: alu_res = alu_a - alu_b;
          F_AND:  alu_res = alu_a & alu_b;
          F_OR:   alu_res = alu_a | alu_b;
          F_NOR:  alu_res = ~(alu_a | alu_b);
          F_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
          F_SLTU: alu_res = {31'd0, alu_a < alu_b};
          F_SLL:  alu_res = alu_b << shamt;
          F_SRL:  alu_res = alu_b >> shamt;
          F_MFHI: alu_res = hi_q;
          F_MFLO: alu_res = lo_q;
          default: alu_res = 32'd0;
        endcase
      end
      default: alu_res = alu_a + alu_b;
    endcase
  end

  // Shift-add multiply step and restoring divide step share the {acc_hi, acc_lo} pair.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_b_q} : 33'd0);
  assign div_sh  = {acc_hi_q, acc_lo_q[31]};
  assign prod    = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    op_b_d      = op_b_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    unique case (state_q)
      S_IDLE: if (md_issue) begin
        is_div_d    = funct[1];
        is_signed_d = !funct[0];
        sign_a_d    = !funct[0] && alu_a[31];
        sign_b_d    = !funct[0] && alu_b[31];
        acc_hi_d    = 32'd0;
        acc_lo_d    = (!funct[0] && alu_a[31]) ? -alu_a : alu_a;
        op_b_d      = (!funct[0] && alu_b[31]) ? -alu_b : alu_b;
        cnt_d       = 6'd0;
        state_d     = S_BUSY;
      end
      S_BUSY: begin
        if (is_div_q) begin
          if (div_sh >= {1'b0, op_b_q}) begin
            acc_hi_d = div_sh[31:0] - op_b_q;
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = div_sh[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[32:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MD_STEPS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (is_div_q) begin
          lo_d = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
          hi_d = sign_a_q ? -acc_hi_q : acc_hi_q;
        end else if (sign_a_q ^ sign_b_q) begin
          {hi_d, lo_d} = -prod;
        end else begin
          {hi_d, lo_d} = prod;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The DONE cycle lets the mul/div instruction through but never as a GPR write.
  always_comb begin
    regwrite_d = !bubble && ctrl_regWrite_id_ex && (state_q != S_DONE);
    memtoreg_d = !bubble && ctrl_memToReg_id_ex;
    branch_d   = !bubble && ctrl_branch_id_ex;
    memread_d  = !bubble && ctrl_memRead_id_ex;
    memwrite_d = !bubble && ctrl_memWrite_id_ex;
    baddr_d    = supposed_next_address_id_ex + {extended_branch_offset_id_ex[29:0], 2'b00};
    result_d   = alu_res;
    zero_d     = (alu_res == 32'd0);
    wdata_d    = read_data_2_id_ex;
    wreg_d     = ctrl_regDest_id_ex ? next_instruction_15_11_id_ex : next_instruction_20_16_id_ex;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  cnt_q <= '0;
      acc_hi_q <= '0;  acc_lo_q <= '0;  op_b_q <= '0;
      is_div_q <= 1'b0;  is_signed_q <= 1'b0;  sign_a_q <= 1'b0;  sign_b_q <= 1'b0;
      hi_q <= '0;  lo_q <= '0;
      regwrite_q <= 1'b0;  memtoreg_q <= 1'b0;  branch_q <= 1'b0;
      memread_q <= 1'b0;  memwrite_q <= 1'b0;  zero_q <= 1'b0;
      baddr_q <= '0;  result_q <= '0;  wdata_q <= '0;  wreg_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      acc_hi_q <= acc_hi_d;  acc_lo_q <= acc_lo_d;  op_b_q <= op_b_d;
      is_div_q <= is_div_d;  is_signed_q <= is_signed_d;
      sign_a_q <= sign_a_d;  sign_b_q <= sign_b_d;
      hi_q <= hi_d;  lo_q <= lo_d;
      regwrite_q <= regwrite_d;  memtoreg_q <= memtoreg_d;  branch_q <= branch_d;
      memread_q <= memread_d;  memwrite_q <= memwrite_d;  zero_q <= zero_d;
      baddr_q <= baddr_d;  result_q <= result_d;  wdata_q <= wdata_d;  wreg_q <= wreg_d;
    end
  end

  assign ctrl_regWrite_ex_mem  = regwrite_q;
  assign ctrl_memToReg_ex_mem  = memtoreg_q;
  assign ctrl_branch_ex_mem    = branch_q;
  assign ctrl_memRead_ex_mem   = memread_q;
  assign ctrl_memWrite_ex_mem  = memwrite_q;
  assign branch_address_ex_mem = baddr_q;
  assign alu_zero_ex_mem       = zero_q;
  assign alu_result_ex_mem     = result_q;
  assign write_data_ex_mem     = wdata_q;
  assign write_register_ex_mem = wreg_q;

endmodule
